// File: rtl/irq_seq_pkg.sv
// Shared constants, bus codes, FSM state type and priority helper for the
// irq_seq_ctrl interrupt front end.
package irq_seq_pkg;

  localparam int NCHAN  = 9;
  localparam int BUS_W  = 2;
  localparam int CHAN_W = 4;

  localparam logic [NCHAN-1:0] MASK_RST_DFLT = 9'h1FF;

  localparam logic [BUS_W-1:0] BUS_A = 2'd0;
  localparam logic [BUS_W-1:0] BUS_B = 2'd1;
  localparam logic [BUS_W-1:0] BUS_C = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PRESENT = 2'b01
  } state_t;

  // Index of the lowest set bit; scanning downward lets the lowest index win.
  function automatic logic [CHAN_W-1:0] lowest_idx(input logic [NCHAN-1:0] vec);
    lowest_idx = '0;
    for (int i = NCHAN - 1; i >= 0; i--) begin
      if (vec[i]) begin
        lowest_idx = CHAN_W'(i);
      end
    end
  endfunction

endpackage

// File: rtl/irq_seq_ctrl_if.sv
// Grant handshake between irq_seq_ctrl (master) and the servicing agent (slave).
interface irq_seq_ctrl_if;

  logic                            irq_valid;
  logic                            irq_ready;
  logic [irq_seq_pkg::BUS_W-1:0]   irq_bus;
  logic [irq_seq_pkg::CHAN_W-1:0]  irq_chan;

  modport master (
    output irq_valid,
    output irq_bus,
    output irq_chan,
    input  irq_ready
  );

  modport slave (
    input  irq_valid,
    input  irq_bus,
    input  irq_chan,
    output irq_ready
  );

endinterface

// File: rtl/irq_seq_ctrl_prio_enc.sv
// Combinational fixed-priority picker: bus A > B > C, lowest channel first.
module irq_prio_enc
  import irq_seq_pkg::*;
(
  input  logic [NCHAN-1:0]  elig_a,
  input  logic [NCHAN-1:0]  elig_b,
  input  logic [NCHAN-1:0]  elig_c,
  output logic              found,
  output logic [BUS_W-1:0]  bus,
  output logic [CHAN_W-1:0] chan
);

  always_comb begin
    found = 1'b0;
    bus   = BUS_A;
    chan  = '0;
    if (|elig_a) begin
      found = 1'b1;
      bus   = BUS_A;
      chan  = lowest_idx(elig_a);
    end else if (|elig_b) begin
      found = 1'b1;
      bus   = BUS_B;
      chan  = lowest_idx(elig_b);
    end else if (|elig_c) begin
      found = 1'b1;
      bus   = BUS_C;
      chan  = lowest_idx(elig_c);
    end
  end

endmodule

// File: rtl/irq_seq_ctrl.sv
// Interrupt sequencer: pending capture, shared enable mask, one-at-a-time grant.
// Define IRQ_SEQ_EDGE_EN for edge-triggered pending; level sampling otherwise.
module irq_seq_ctrl
  import irq_seq_pkg::*;
#(
  parameter logic [NCHAN-1:0] MASK_RST = MASK_RST_DFLT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NCHAN-1:0]   req_a,
  input  logic [NCHAN-1:0]   req_b,
  input  logic [NCHAN-1:0]   req_c,
  input  logic               mask_we,
  input  logic [NCHAN-1:0]   mask_wdata,
  output logic [2:0]         pend_any,
  irq_seq_ctrl_if.master     irq
);

  state_t             state;
  state_t             state_next;
  logic               load;
  logic [NCHAN-1:0]   pend_a;
  logic [NCHAN-1:0]   pend_b;
  logic [NCHAN-1:0]   pend_c;
  logic [NCHAN-1:0]   mask;
  logic [NCHAN-1:0]   elig_a;
  logic [NCHAN-1:0]   elig_b;
  logic [NCHAN-1:0]   elig_c;
  logic               win_found;
  logic [BUS_W-1:0]   win_bus;
  logic [CHAN_W-1:0]  win_chan;
  logic [BUS_W-1:0]   bus_q;
  logic [CHAN_W-1:0]  chan_q;

  assign elig_a   = pend_a & mask;
  assign elig_b   = pend_b & mask;
  assign elig_c   = pend_c & mask;
  assign pend_any = {|elig_c, |elig_b, |elig_a};

  irq_prio_enc u_prio (
    .elig_a (elig_a),
    .elig_b (elig_b),
    .elig_c (elig_c),
    .found  (win_found),
    .bus    (win_bus),
    .chan   (win_chan)
  );

  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (win_found) begin
          load       = 1'b1;
          state_next = PRESENT;
        end
      end
      PRESENT: begin
        if (irq.irq_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The grant is captured only on leaving IDLE, so it cannot move while presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_q  <= BUS_A;
      chan_q <= '0;
    end else if (load) begin
      bus_q  <= win_bus;
      chan_q <= win_chan;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask <= MASK_RST;
    end else if (mask_we) begin
      mask <= mask_wdata;
    end
  end

`ifdef IRQ_SEQ_EDGE_EN
  logic [NCHAN-1:0] req_q_a;
  logic [NCHAN-1:0] req_q_b;
  logic [NCHAN-1:0] req_q_c;
  logic [NCHAN-1:0] clr_a;
  logic [NCHAN-1:0] clr_b;
  logic [NCHAN-1:0] clr_c;
  logic [NCHAN-1:0] chan_onehot;

  assign chan_onehot = NCHAN'(1) << chan_q;

  always_comb begin
    clr_a = '0;
    clr_b = '0;
    clr_c = '0;
    if ((state == PRESENT) && irq.irq_ready) begin
      case (bus_q)
        BUS_A:   clr_a = chan_onehot;
        BUS_B:   clr_b = chan_onehot;
        BUS_C:   clr_c = chan_onehot;
        default: ;
      endcase
    end
  end

  // Set is OR-ed after the clear so a new edge in the accept cycle survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q_a <= '0;
      req_q_b <= '0;
      req_q_c <= '0;
      pend_a  <= '0;
      pend_b  <= '0;
      pend_c  <= '0;
    end else begin
      req_q_a <= req_a;
      req_q_b <= req_b;
      req_q_c <= req_c;
      pend_a  <= (pend_a & ~clr_a) | (req_a & ~req_q_a);
      pend_b  <= (pend_b & ~clr_b) | (req_b & ~req_q_b);
      pend_c  <= (pend_c & ~clr_c) | (req_c & ~req_q_c);
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_a <= '0;
      pend_b <= '0;
      pend_c <= '0;
    end else begin
      pend_a <= req_a;
      pend_b <= req_b;
      pend_c <= req_c;
    end
  end
`endif

  assign irq.irq_valid = (state == PRESENT);
  assign irq.irq_bus   = bus_q;
  assign irq.irq_chan  = chan_q;

endmodule

// File: tb/tb_irq_seq_ctrl.sv
// Directed vector bench for irq_seq_ctrl; expectations follow IRQ_SEQ_EDGE_EN.
module tb_irq_seq_ctrl;

  typedef struct {
    logic [8:0] ra;
    logic [8:0] rb;
    logic [8:0] rc;
    logic       mwe;
    logic [8:0] mwd;
    logic       rdy;
    logic       ev;
    logic [1:0] eb;
    logic [3:0] ec;
    logic [2:0] ep;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [8:0] req_a;
  logic [8:0] req_b;
  logic [8:0] req_c;
  logic       mask_we;
  logic [8:0] mask_wdata;
  logic [2:0] pend_any;
  int         total;
  int         passed;
  vec_t       vecs[$];

  irq_seq_ctrl_if irq_if ();

  irq_seq_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_c      (req_c),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .pend_any   (pend_any),
    .irq        (irq_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic vec_t mk(input logic [8:0] ra, input logic [8:0] rb, input logic [8:0] rc,
                              input logic mwe, input logic [8:0] mwd, input logic rdy,
                              input logic ev, input logic [1:0] eb, input logic [3:0] ec,
                              input logic [2:0] ep);
    vec_t v;
    v.ra = ra; v.rb = rb; v.rc = rc; v.mwe = mwe; v.mwd = mwd; v.rdy = rdy;
    v.ev = ev; v.eb = eb; v.ec = ec; v.ep = ep;
    return v;
  endfunction

  task automatic checkSignal(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    total++;
    if (irq_if.irq_valid === v.ev && irq_if.irq_bus === v.eb &&
        irq_if.irq_chan === v.ec && pend_any === v.ep) begin
      passed++;
    end else begin
      $display("[TB] FAIL vec%0d: got valid=%0b bus=%0d chan=%0d pend_any=%b, expected valid=%0b bus=%0d chan=%0d pend_any=%b",
               idx, irq_if.irq_valid, irq_if.irq_bus, irq_if.irq_chan, pend_any,
               v.ev, v.eb, v.ec, v.ep);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    req_a            = v.ra;
    req_b            = v.rb;
    req_c            = v.rc;
    mask_we          = v.mwe;
    mask_wdata       = v.mwd;
    irq_if.irq_ready = v.rdy;
    @(posedge clk);
    #1;
    checkOutput(v, idx);
  endtask

  task automatic fillVectors();
`ifdef IRQ_SEQ_EDGE_EN
    vecs.push_back(mk(9'h000, 9'h000, 9'h000, 0, 9'h000, 0, 0, 0, 0, 3'b000));
    vecs.push_back(mk(9'h000, 9'h008, 9'h001, 0, 9'h000, 0, 0, 0, 0, 3'b110));
    vecs.push_back(mk(9'h000, 9'h000, 9'h000, 0, 9'h000, 1, 1, 1, 3, 3'b110));
    vecs.push_back(mk(9'h000, 9'h000, 9'h000, 0, 9'h000, 1, 0, 1, 3, 3'b100));
    vecs.push_back(mk(9'h000, 9'h000, 9'h000, 0, 9'h000, 1, 1, 2, 0, 3'b100));
    vecs.push_back(mk(9'h000, 9'h000, 9'h000, 0, 9'h000, 1, 0, 2, 0, 3'b000));
    vecs.push_back(mk(9'h000, 9'h000, 9'h000, 0, 9'h000, 1, 0, 2, 0, 3'b000));
    vecs.push_back(mk(9'h000, 9'h020, 9'h000, 0, 9'h000, 0, 0, 2, 0, 3'b010));
    vecs.push_back(mk(9'h000, 9'h020, 9'h000, 0, 9'h000, 0, 1, 1, 5, 3'b010));
    for (int i = 0; i < 4; i++) begin
      vecs.push_back(mk(9'h100, 9'h020, 9'h000, 0, 9'h000, 0, 1, 1, 5, 3'b011));
    end
    vecs.push_back(mk(9'h100, 9'h020, 9'h000, 0, 9'h000, 1, 0, 1, 5, 3'b001));
    vecs.push_back(mk(9'h100, 9'h020, 9'h000, 0, 9'h000, 1, 1, 0, 8, 3'b001));
    vecs.push_back(mk(9'h000, 9'h000, 9'h000, 0, 9'h000, 1, 0, 0, 8, 3'b000));
    vecs.push_back(mk(9'h000, 9'h000, 9'h000, 0, 9'h000, 1, 0, 0, 8, 3'b000));
    vecs.push_back(mk(9'h004, 9'h000, 9'h000, 1, 9'h1FB, 0, 0, 0, 8, 3'b000));
    vecs.push_back(mk(9'h000, 9'h000, 9'h000, 0, 9'h000, 0, 0, 0, 8, 3'b000));
    vecs.push_back(mk(9'h000, 9'h000, 9'h000, 1, 9'h1FF, 0, 0, 0, 8, 3'b001));
    vecs.push_back(mk(9'h000, 9'h000, 9'h000, 0, 9'h000, 0, 1, 0, 2, 3'b001));
    vecs.push_back(mk(9'h000, 9'h000, 9'h000, 0, 9'h000, 1, 0, 0, 2, 3'b000));
    vecs.push_back(mk(9'h000, 9'h000, 9'h010, 0, 9'h000, 0, 0, 0, 2, 3'b100));
    vecs.push_back(mk(9'h000, 9'h000, 9'h000, 0, 9'h000, 0, 1, 2, 4, 3'b100));
    vecs.push_back(mk(9'h000, 9'h000, 9'h010, 0, 9'h000, 1, 0, 2, 4, 3'b100));
    vecs.push_back(mk(9'h000, 9'h000, 9'h000, 0, 9'h000, 1, 1, 2, 4, 3'b100));
    vecs.push_back(mk(9'h000, 9'h000, 9'h000, 0, 9'h000, 1, 0, 2, 4, 3'b000));
    vecs.push_back(mk(9'h000, 9'h000, 9'h000, 0, 9'h000, 1, 0, 2, 4, 3'b000));
`else
    vecs.push_back(mk(9'h000, 9'h000, 9'h000, 0, 9'h000, 0, 0, 0, 0, 3'b000));
    vecs.push_back(mk(9'h000, 9'h008, 9'h001, 0, 9'h000, 0, 0, 0, 0, 3'b110));
    vecs.push_back(mk(9'h000, 9'h008, 9'h001, 0, 9'h000, 0, 1, 1, 3, 3'b110));
    vecs.push_back(mk(9'h000, 9'h000, 9'h001, 0, 9'h000, 1, 0, 1, 3, 3'b100));
    vecs.push_back(mk(9'h000, 9'h000, 9'h001, 0, 9'h000, 1, 1, 2, 0, 3'b100));
    vecs.push_back(mk(9'h000, 9'h000, 9'h000, 0, 9'h000, 1, 0, 2, 0, 3'b000));
    vecs.push_back(mk(9'h000, 9'h000, 9'h000, 0, 9'h000, 1, 0, 2, 0, 3'b000));
    vecs.push_back(mk(9'h110, 9'h001, 9'h000, 0, 9'h000, 0, 0, 2, 0, 3'b011));
    vecs.push_back(mk(9'h110, 9'h001, 9'h000, 0, 9'h000, 0, 1, 0, 4, 3'b011));
    vecs.push_back(mk(9'h110, 9'h001, 9'h000, 1, 9'h000, 0, 1, 0, 4, 3'b000));
    vecs.push_back(mk(9'h000, 9'h000, 9'h000, 1, 9'h1FF, 1, 0, 0, 4, 3'b000));
    vecs.push_back(mk(9'h000, 9'h000, 9'h000, 0, 9'h000, 0, 0, 0, 4, 3'b000));
    vecs.push_back(mk(9'h004, 9'h000, 9'h000, 1, 9'h1FB, 0, 0, 0, 4, 3'b000));
    vecs.push_back(mk(9'h004, 9'h000, 9'h000, 0, 9'h000, 0, 0, 0, 4, 3'b000));
    vecs.push_back(mk(9'h004, 9'h000, 9'h000, 1, 9'h1FF, 0, 0, 0, 4, 3'b001));
    vecs.push_back(mk(9'h004, 9'h000, 9'h000, 0, 9'h000, 0, 1, 0, 2, 3'b001));
    vecs.push_back(mk(9'h004, 9'h000, 9'h000, 0, 9'h000, 1, 0, 0, 2, 3'b001));
    vecs.push_back(mk(9'h004, 9'h000, 9'h000, 0, 9'h000, 1, 1, 0, 2, 3'b001));
    vecs.push_back(mk(9'h000, 9'h000, 9'h000, 0, 9'h000, 1, 0, 0, 2, 3'b000));
`endif
  endtask

  initial begin
    logic got_valid;
    logic stayed_quiet;
    logic exp_valid;

    total            = 0;
    passed           = 0;
    rst_n            = 1'b0;
    req_a            = '0;
    req_b            = '0;
    req_c            = '0;
    mask_we          = 1'b0;
    mask_wdata       = '0;
    irq_if.irq_ready = 1'b0;

    #2;
    checkSignal("reset_valid", 32'(irq_if.irq_valid), 32'd0);
    checkSignal("reset_grant", 32'({irq_if.irq_bus, irq_if.irq_chan}), 32'd0);
    checkSignal("reset_pend_any", 32'(pend_any), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    fillVectors();
    foreach (vecs[i]) begin
      applyStimulus(vecs[i], i);
    end

    // Asynchronous reset while a grant is being presented.
    req_b            = 9'h020;
    irq_if.irq_ready = 1'b0;
    got_valid        = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (irq_if.irq_valid) begin
        got_valid = 1'b1;
        break;
      end
    end
    checkSignal("pre_reset_valid", 32'(got_valid), 32'd1);
    checkSignal("pre_reset_grant", 32'({irq_if.irq_bus, irq_if.irq_chan}), 32'h15);
    #3;
    rst_n = 1'b0;
    #1;
    checkSignal("midreset_valid", 32'(irq_if.irq_valid), 32'd0);
    checkSignal("midreset_grant", 32'({irq_if.irq_bus, irq_if.irq_chan}), 32'd0);
    checkSignal("midreset_pend_any", 32'(pend_any), 32'd0);
    req_b = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    stayed_quiet = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (irq_if.irq_valid || pend_any != 3'b000) stayed_quiet = 1'b0;
    end
    checkSignal("post_reset_quiet", 32'(stayed_quiet), 32'd1);

    // Request held high with the consumer always ready.
    req_a            = 9'h002;
    irq_if.irq_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
`ifdef IRQ_SEQ_EDGE_EN
      exp_valid = (k == 1);
`else
      exp_valid = (k % 2 == 1);
`endif
      checkSignal($sformatf("hold_valid_%0d", k), 32'(irq_if.irq_valid), 32'(exp_valid));
      if (exp_valid) begin
        checkSignal($sformatf("hold_grant_%0d", k),
                    32'({irq_if.irq_bus, irq_if.irq_chan}), 32'h01);
      end
    end
    req_a = '0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      checkSignal($sformatf("drop_valid_%0d", k), 32'(irq_if.irq_valid), 32'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
